// File: rtl/mbinit_param_checker.sv
// MBINIT.PARAM exchange: captures the partner request, negotiates against the local set and returns the response.
// Optional define PARAM_CHK_VSWING_EN adds a voltage-swing legality check (error code 11) in CHECK.
module mbinit_param_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 16'd8000,
  parameter int          CNT_W          = 16
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [4:0] i_local_vswing,
  input  logic [2:0] i_local_max_rate,
  input  logic       i_local_clk_mode,
  input  logic       i_local_phase_clk,
  input  logic       i_rx_valid,
  input  logic [4:0] i_rx_vswing,
  input  logic [2:0] i_rx_max_rate,
  input  logic       i_rx_clk_mode,
  input  logic       i_rx_phase_clk,
  output logic       o_tx_rsp_valid,
  input  logic       i_tx_rsp_ready,
  output logic [2:0] o_tx_rsp_max_rate,
  output logic       o_tx_rsp_clk_mode,
  output logic       o_tx_rsp_phase_clk,
  output logic       o_Enable_Checker,
  output logic [2:0] o_Final_MaxDataRate,
  output logic       o_done,
  output logic       o_error,
  output logic [1:0] o_error_code
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_REQ = 3'd1,
    CHECK    = 3'd2,
    SEND_RSP = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_RATE = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
`ifdef PARAM_CHK_VSWING_EN
  localparam logic [1:0] ERR_VSW  = 2'b11;
`endif

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [2:0] min_rate(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic rate_invalid(input logic [2:0] loc, input logic [2:0] rx);
    return (loc == 3'd0) || (rx == 3'd0);
  endfunction

`ifdef PARAM_CHK_VSWING_EN
  // Partner may not ask for more swing than we drive, and zero swing is never legal.
  function automatic logic vswing_bad(input logic [4:0] loc, input logic [4:0] rx);
    return (rx > loc) || (rx == 5'd0);
  endfunction
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       rx_rate_q, rx_rate_d;
  logic             rx_clk_q, rx_clk_d;
  logic             rx_phase_q, rx_phase_d;
  logic [4:0]       rx_vswing_q, rx_vswing_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [2:0]       rsp_rate_q, rsp_rate_d;
  logic             rsp_clk_q, rsp_clk_d;
  logic             rsp_phase_q, rsp_phase_d;
  logic             enable_q, enable_d;
  logic [2:0]       final_rate_q, final_rate_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;

`ifndef PARAM_CHK_VSWING_EN
  logic unused_vswing;
  assign unused_vswing = ^{i_local_vswing, rx_vswing_q};
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_rate_d    = rx_rate_q;
    rx_clk_d     = rx_clk_q;
    rx_phase_d   = rx_phase_q;
    rx_vswing_d  = rx_vswing_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rate_d   = rsp_rate_q;
    rsp_clk_d    = rsp_clk_q;
    rsp_phase_d  = rsp_phase_q;
    enable_d     = 1'b0;
    final_rate_d = final_rate_q;
    done_d       = done_q;
    error_d      = error_q;
    err_code_d   = err_code_q;

    // A start pulse always wins, whatever else is happening this cycle.
    if (i_start) begin
      state_d     = WAIT_REQ;
      cnt_d       = '0;
      rsp_valid_d = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;
      err_code_d  = ERR_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d      = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
        end

        WAIT_REQ: begin
          if (i_rx_valid) begin
            rx_rate_d   = i_rx_max_rate;
            rx_clk_d    = i_rx_clk_mode;
            rx_phase_d  = i_rx_phase_clk;
            rx_vswing_d = i_rx_vswing;
            state_d     = CHECK;
          end else if (cnt_q == TMO_LAST) begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_code_d = ERR_TMO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        CHECK: begin
          if (rate_invalid(i_local_max_rate, rx_rate_q)) begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_code_d = ERR_RATE;
`ifdef PARAM_CHK_VSWING_EN
          end else if (vswing_bad(i_local_vswing, rx_vswing_q)) begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_code_d = ERR_VSW;
`endif
          end else begin
            rsp_rate_d   = min_rate(i_local_max_rate, rx_rate_q);
            rsp_clk_d    = i_local_clk_mode & rx_clk_q;
            rsp_phase_d  = i_local_phase_clk & rx_phase_q;
            final_rate_d = min_rate(i_local_max_rate, rx_rate_q);
            rsp_valid_d  = 1'b1;
            enable_d     = 1'b1;
            cnt_d        = '0;
            state_d      = SEND_RSP;
          end
        end

        // Response fields are frozen here; only valid changes on exit.
        SEND_RSP: begin
          if (i_tx_rsp_ready) begin
            rsp_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end else if (cnt_q == TMO_LAST) begin
            rsp_valid_d = 1'b0;
            error_d     = 1'b1;
            err_code_d  = ERR_TMO;
            state_d     = ERROR;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        DONE, ERROR: begin
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rx_rate_q    <= '0;
      rx_clk_q     <= 1'b0;
      rx_phase_q   <= 1'b0;
      rx_vswing_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rate_q   <= '0;
      rsp_clk_q    <= 1'b0;
      rsp_phase_q  <= 1'b0;
      enable_q     <= 1'b0;
      final_rate_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rx_rate_q    <= rx_rate_d;
      rx_clk_q     <= rx_clk_d;
      rx_phase_q   <= rx_phase_d;
      rx_vswing_q  <= rx_vswing_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rate_q   <= rsp_rate_d;
      rsp_clk_q    <= rsp_clk_d;
      rsp_phase_q  <= rsp_phase_d;
      enable_q     <= enable_d;
      final_rate_q <= final_rate_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
    end
  end

  assign o_tx_rsp_valid      = rsp_valid_q;
  assign o_tx_rsp_max_rate   = rsp_rate_q;
  assign o_tx_rsp_clk_mode   = rsp_clk_q;
  assign o_tx_rsp_phase_clk  = rsp_phase_q;
  assign o_Enable_Checker    = enable_q;
  assign o_Final_MaxDataRate = final_rate_q;
  assign o_done              = done_q;
  assign o_error             = error_q;
  assign o_error_code        = err_code_q;

endmodule

// File: tb/tb_mbinit_param_checker.sv
// Scoreboard bench for mbinit_param_checker: stimulus pushes expected events, a monitor pops them as the DUT shows them.
module tb_mbinit_param_checker;

  localparam int T = 16;
  localparam int K_RSP = 0, K_DONE = 1, K_ERR = 2, K_DROP = 3, K_CLEAR = 4;

  typedef struct {
    int         kind;
    int         at;
    logic [2:0] rate;
    logic       clk;
    logic       ph;
    logic [1:0] code;
  } exp_t;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       i_start, i_rx_valid, i_tx_rsp_ready;
  logic [4:0] i_local_vswing, i_rx_vswing;
  logic [2:0] i_local_max_rate, i_rx_max_rate;
  logic       i_local_clk_mode, i_local_phase_clk, i_rx_clk_mode, i_rx_phase_clk;
  logic       o_tx_rsp_valid, o_tx_rsp_clk_mode, o_tx_rsp_phase_clk;
  logic [2:0] o_tx_rsp_max_rate, o_Final_MaxDataRate;
  logic       o_Enable_Checker, o_done, o_error;
  logic [1:0] o_error_code;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic       exp_done = 1'b0, exp_err = 1'b0;
  logic [2:0] exp_final = 3'd0;

  mbinit_param_checker #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .CLK(CLK), .rst_n(rst_n), .i_start(i_start),
    .i_local_vswing(i_local_vswing), .i_local_max_rate(i_local_max_rate),
    .i_local_clk_mode(i_local_clk_mode), .i_local_phase_clk(i_local_phase_clk),
    .i_rx_valid(i_rx_valid), .i_rx_vswing(i_rx_vswing), .i_rx_max_rate(i_rx_max_rate),
    .i_rx_clk_mode(i_rx_clk_mode), .i_rx_phase_clk(i_rx_phase_clk),
    .o_tx_rsp_valid(o_tx_rsp_valid), .i_tx_rsp_ready(i_tx_rsp_ready),
    .o_tx_rsp_max_rate(o_tx_rsp_max_rate), .o_tx_rsp_clk_mode(o_tx_rsp_clk_mode),
    .o_tx_rsp_phase_clk(o_tx_rsp_phase_clk), .o_Enable_Checker(o_Enable_Checker),
    .o_Final_MaxDataRate(o_Final_MaxDataRate), .o_done(o_done), .o_error(o_error),
    .o_error_code(o_error_code)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  function automatic string kname(input int k);
    case (k)
      K_RSP:   return "rsp";
      K_DONE:  return "done";
      K_ERR:   return "error";
      K_DROP:  return "drop";
      default: return "clear";
    endcase
  endfunction

  task automatic push(input int kind, input int at, input logic [2:0] rate,
                      input logic clk, input logic ph, input logic [1:0] code);
    exp_t e;
    e.kind = kind; e.at = at; e.rate = rate; e.clk = clk; e.ph = ph; e.code = code;
    sb.push_back(e);
  endtask

  // Reference outcome of CHECK, straight from the negotiation rules.
  function automatic exp_t model(input logic [2:0] lr, input logic [2:0] rr,
                                 input logic lc, input logic rc, input logic lp, input logic rp,
                                 input logic [4:0] lv, input logic [4:0] rv);
    exp_t e;
    e.at = 0; e.rate = exp_final; e.clk = 1'b0; e.ph = 1'b0; e.code = 2'b00;
    e.kind = K_RSP;
    if (lr == 3'd0 || rr == 3'd0) begin
      e.kind = K_ERR; e.code = 2'b01;
    end
`ifdef PARAM_CHK_VSWING_EN
    else if (rv > lv || rv == 5'd0) begin
      e.kind = K_ERR; e.code = 2'b11;
    end
`endif
    else begin
      e.rate = (lr < rr) ? lr : rr;
      e.clk  = lc & rc;
      e.ph   = lp & rp;
    end
    if (lv === 5'bx && rv === 5'bx) e.at = 0;
    return e;
  endfunction

  // ---------------- monitor ----------------
  logic       p_valid = 1'b0, p_done = 1'b0, p_err = 1'b0;
  logic [2:0] l_rate;
  logic       l_clk, l_ph;

  task automatic pop_chk(input int kind);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL evt_%s: got unexpected event at cyc %0d, expected none", kname(kind), cyc);
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind || e.at != cyc) begin
      n_err++;
      $display("FAIL evt_order: got %s at cyc %0d, expected %s at cyc %0d",
               kname(kind), cyc, kname(e.kind), e.at);
      return;
    end
    case (kind)
      K_RSP: begin
        chk("rsp_rate", o_tx_rsp_max_rate, e.rate);
        chk("rsp_clk", o_tx_rsp_clk_mode, e.clk);
        chk("rsp_phase", o_tx_rsp_phase_clk, e.ph);
        chk("final_rate", o_Final_MaxDataRate, e.rate);
      end
      K_DONE: begin
        chk("done_valid_low", o_tx_rsp_valid, 0);
        chk("done_no_error", o_error, 0);
      end
      K_ERR: begin
        chk("error_code", o_error_code, e.code);
        chk("error_final_kept", o_Final_MaxDataRate, e.rate);
        chk("error_valid_low", o_tx_rsp_valid, 0);
      end
      K_DROP: begin
        chk("drop_flags", {o_done, o_error}, 0);
        chk("drop_final_kept", o_Final_MaxDataRate, e.rate);
      end
      default: begin
        chk("clear_flags", {o_done, o_error, o_error_code}, 0);
      end
    endcase
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (rst_n) begin
        logic v_rise, v_fall, d_rise, e_rise, d_fall, e_fall;
        v_rise = o_tx_rsp_valid && !p_valid;
        v_fall = !o_tx_rsp_valid && p_valid;
        d_rise = o_done && !p_done;
        e_rise = o_error && !p_err;
        d_fall = !o_done && p_done;
        e_fall = !o_error && p_err;
        chk("enable_first_cycle_only", o_Enable_Checker, v_rise);
        if (v_rise) begin
          pop_chk(K_RSP);
          l_rate = o_tx_rsp_max_rate; l_clk = o_tx_rsp_clk_mode; l_ph = o_tx_rsp_phase_clk;
        end else if (o_tx_rsp_valid) begin
          chk("rsp_stable", {o_tx_rsp_max_rate, o_tx_rsp_clk_mode, o_tx_rsp_phase_clk},
              {l_rate, l_clk, l_ph});
        end
        if (d_rise) pop_chk(K_DONE);
        if (e_rise) pop_chk(K_ERR);
        if (v_fall && !d_rise && !e_rise) pop_chk(K_DROP);
        if (d_fall || e_fall) pop_chk(K_CLEAR);
      end
      p_valid = o_tx_rsp_valid;
      p_done  = o_done;
      p_err   = o_error;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic go_to(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic set_local(input logic [2:0] r, input logic c, input logic p, input logic [4:0] v);
    i_local_max_rate = r; i_local_clk_mode = c; i_local_phase_clk = p; i_local_vswing = v;
  endtask

  task automatic do_start(output int wq);
    int k;
    step();
    k = cyc;
    i_start = 1'b1;
    i_rx_valid = 1'($urandom_range(0, 1));
    i_rx_max_rate = 3'($urandom_range(0, 7));
    if (exp_done || exp_err) push(K_CLEAR, k + 1, 3'd0, 1'b0, 1'b0, 2'b00);
    exp_done = 1'b0; exp_err = 1'b0;
    step();
    i_start = 1'b0; i_rx_valid = 1'b0;
    wq = k + 1;
  endtask

  // mode 0: ready after lag cycles; 1: restart after lag cycles of SEND_RSP; 2: reset mid SEND_RSP
  task automatic do_request(input int wq, input int d, input logic [2:0] rr, input logic rc,
                            input logic rp, input logic [4:0] rv, input int lag, input int mode,
                            output int nwq);
    exp_t e;
    int n, endc;
    nwq = -1;
    if (d >= T) begin
      push(K_ERR, wq + T, exp_final, 1'b0, 1'b0, 2'b10);
      exp_err = 1'b1;
      go_to(wq + T);
      return;
    end
    go_to(wq + d);
    n = cyc;
    i_rx_valid = 1'b1; i_rx_max_rate = rr; i_rx_clk_mode = rc; i_rx_phase_clk = rp; i_rx_vswing = rv;
    step();
    i_rx_valid = 1'b0;
    i_rx_max_rate = 3'($urandom_range(0, 7));
    i_rx_clk_mode = 1'($urandom_range(0, 1));
    i_rx_phase_clk = 1'($urandom_range(0, 1));
    i_rx_vswing = 5'($urandom_range(0, 31));
    e = model(i_local_max_rate, rr, i_local_clk_mode, rc, i_local_phase_clk, rp, i_local_vswing, rv);
    if (e.kind == K_ERR) begin
      push(K_ERR, n + 2, exp_final, 1'b0, 1'b0, e.code);
      exp_err = 1'b1;
      go_to(n + 2);
      return;
    end
    push(K_RSP, n + 2, e.rate, e.clk, e.ph, 2'b00);
    exp_final = e.rate;
    if (mode == 1) begin
      while (cyc < n + 2 + lag) begin
        i_tx_rsp_ready = (cyc < n + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
      end
      i_start = 1'b1; i_tx_rsp_ready = 1'b1; i_rx_valid = 1'b1;
      push(K_DROP, n + 3 + lag, exp_final, 1'b0, 1'b0, 2'b00);
      step();
      i_start = 1'b0; i_tx_rsp_ready = 1'b0; i_rx_valid = 1'b0;
      nwq = cyc;
      return;
    end
    if (mode == 2) begin
      i_tx_rsp_ready = 1'b0;
      go_to(n + 4);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", o_tx_rsp_valid, 0);
      chk("rst_mid_enable", o_Enable_Checker, 0);
      chk("rst_mid_final", o_Final_MaxDataRate, 0);
      chk("rst_mid_flags", {o_done, o_error, o_error_code}, 0);
      exp_final = 3'd0;
      step();
      #2 rst_n = 1'b1;
      return;
    end
    if (lag < T) begin
      endc = n + 3 + lag;
      push(K_DONE, endc, 3'd0, 1'b0, 1'b0, 2'b00);
      exp_done = 1'b1;
    end else begin
      endc = n + 2 + T;
      push(K_ERR, endc, exp_final, 1'b0, 1'b0, 2'b10);
      exp_err = 1'b1;
    end
    while (cyc < endc) begin
      if (cyc < n + 2) i_tx_rsp_ready = 1'($urandom_range(0, 1));
      else i_tx_rsp_ready = (cyc >= n + 2 + lag) ? 1'b1 : 1'b0;
      step();
    end
    i_tx_rsp_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    int wq, nwq, d, lag, mode;
    logic [2:0] rr;
    rst_n = 1'b0; i_start = 1'b0; i_rx_valid = 1'b0; i_tx_rsp_ready = 1'b0;
    i_rx_max_rate = 3'd0; i_rx_clk_mode = 1'b0; i_rx_phase_clk = 1'b0; i_rx_vswing = 5'd0;
    set_local(3'd3, 1'b1, 1'b0, 5'd21);
    repeat (3) step();
    chk("reset_valid", o_tx_rsp_valid, 0);
    chk("reset_enable", o_Enable_Checker, 0);
    chk("reset_final", o_Final_MaxDataRate, 0);
    chk("reset_flags", {o_done, o_error, o_error_code}, 0);
    chk("reset_rsp_fields", {o_tx_rsp_max_rate, o_tx_rsp_clk_mode, o_tx_rsp_phase_clk}, 0);
    #2 rst_n = 1'b1;

    // nominal, ready already high
    do_start(wq); do_request(wq, 2, 3'd5, 1'b1, 1'b1, 5'd21, 0, 0, nwq);
    // invalid partner rate keeps the previous final rate
    do_start(wq); do_request(wq, 1, 3'd0, 1'b1, 1'b1, 5'd10, 0, 0, nwq);
    // request timeout
    do_start(wq); do_request(wq, T, 3'd2, 1'b0, 1'b0, 5'd1, 0, 0, nwq);
    // accepted on the last legal WAIT_REQ cycle
    do_start(wq); do_request(wq, T - 1, 3'd2, 1'b0, 1'b1, 5'd1, 0, 0, nwq);
    // backpressure for 5 cycles
    do_start(wq); do_request(wq, 0, 3'd6, 1'b1, 1'b0, 5'd5, 5, 0, nwq);
    // response timeout
    do_start(wq); do_request(wq, 3, 3'd2, 1'b0, 1'b1, 5'd5, T + 1, 0, nwq);
    // restart during SEND_RSP, then renegotiate
    do_start(wq); do_request(wq, 1, 3'd7, 1'b1, 1'b1, 5'd5, 2, 1, nwq);
    do_request(nwq, 2, 3'd1, 1'b1, 1'b0, 5'd3, 1, 0, nwq);
    // local rate zero
    set_local(3'd0, 1'b1, 1'b1, 5'd21);
    do_start(wq); do_request(wq, 0, 3'd5, 1'b1, 1'b1, 5'd4, 0, 0, nwq);
`ifdef PARAM_CHK_VSWING_EN
    set_local(3'd3, 1'b1, 1'b1, 5'd21);
    do_start(wq); do_request(wq, 1, 3'd4, 1'b1, 1'b1, 5'd22, 0, 0, nwq);
    do_start(wq); do_request(wq, 1, 3'd4, 1'b1, 1'b1, 5'd21, 0, 0, nwq);
    do_start(wq); do_request(wq, 1, 3'd0, 1'b1, 1'b1, 5'd22, 0, 0, nwq);
    do_start(wq); do_request(wq, 1, 3'd4, 1'b1, 1'b1, 5'd0, 0, 0, nwq);
`endif
    // reset in the middle of SEND_RSP
    set_local(3'd4, 1'b1, 1'b1, 5'd20);
    do_start(wq); do_request(wq, 1, 3'd6, 1'b1, 1'b1, 5'd3, 0, 2, nwq);

    for (int i = 0; i < 40; i++) begin
      set_local(($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      rr   = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      d    = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, 5);
      lag  = ($urandom_range(0, 9) == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, 6);
      mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
      do_start(wq);
      do_request(wq, d, rr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), lag, mode, nwq);
      if (nwq >= 0)
        do_request(nwq, $urandom_range(0, 4), 3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom_range(0, 3), 0, nwq);
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (5) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mbinit_param_checker.md
Name: mbinit_param_checker

Overview:
- Runs the MBINIT.PARAM exchange for the LTSM.
- Captures the link partner's parameter-exchange request from the sideband decoder and compares it with the local parameter set held by the MBINIT parameter register.
- Computes the negotiated parameters and returns the response to the sideband encoder.
- Pulses the enable and supplies the negotiated max data rate that the parameter register latches as its final data rate.

Parameters:
- TIMEOUT_CYCLES, 16'd8000: cycles allowed in WAIT_REQ or SEND_RSP before a timeout error.
- CNT_W, 16: timeout counter width; TIMEOUT_CYCLES must fit in CNT_W bits.

Ports:
- CLK  input  1  block clock
- rst_n  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle pulse on entry to MBINIT.PARAM
- i_local_vswing  input  5  local TX voltage swing
- i_local_max_rate  input  3  local max data rate code
- i_local_clk_mode  input  1  local clock mode
- i_local_phase_clk  input  1  local clock phase
- i_rx_valid  input  1  partner param request decoded (one-cycle pulse)
- i_rx_vswing  input  5  partner voltage swing
- i_rx_max_rate  input  3  partner max data rate code
- i_rx_clk_mode  input  1  partner clock mode
- i_rx_phase_clk  input  1  partner clock phase
- o_tx_rsp_valid  output  1  response valid to sideband encoder
- i_tx_rsp_ready  input  1  encoder accepts response
- o_tx_rsp_max_rate  output  3  negotiated rate in response
- o_tx_rsp_clk_mode  output  1  negotiated clock mode
- o_tx_rsp_phase_clk  output  1  negotiated clock phase
- o_Enable_Checker  output  1  one-cycle latch-enable to parameter register
- o_Final_MaxDataRate  output  3  negotiated max data rate
- o_done  output  1  exchange completed successfully (sticky)
- o_error  output  1  exchange failed (sticky)
- o_error_code  output  2  01 invalid rate, 10 timeout, 11 vswing violation

Behaviour:
- Reset: all outputs 0 and state IDLE. Reset asserted mid-exchange aborts immediately, with no response and no enable pulse.
- FSM states: IDLE, WAIT_REQ, CHECK, SEND_RSP, DONE, ERROR. All outputs are registered.
- IDLE:
  - i_start moves to WAIT_REQ.
  - Clears o_done, o_error, o_error_code and the timeout counter.
- i_start in any non-IDLE state restarts: next state is WAIT_REQ, with the same clears. The restart takes priority over every other event that cycle, including an rx_valid or a handshake.
- WAIT_REQ:
  - i_rx_valid captures all i_rx_* fields and moves to CHECK.
  - i_rx_valid is ignored outside WAIT_REQ, including the i_start cycle.
  - The counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 without rx_valid, the FSM goes to ERROR with code 10.
- CHECK (exactly one cycle):
  - If the captured rate is 0 or the local rate is 0, go to ERROR with code 01.
  - Otherwise:
    - negotiated rate = min(local, rx), unsigned 3-bit
    - clk_mode = local AND rx
    - phase_clk = local AND rx
  - Load the response registers, set o_Final_MaxDataRate, and go to SEND_RSP with the counter cleared.
- SEND_RSP:
  - o_tx_rsp_valid is high and the response fields are stable until the handshake (valid AND ready).
  - o_Enable_Checker is high only in the first SEND_RSP cycle.
  - A handshake goes to DONE and drops valid the next cycle.
  - No handshake within TIMEOUT_CYCLES cycles goes to ERROR with code 10 and drops valid.
  - Ready is ignored while valid is low.
- Latency: rx_valid at cycle N gives o_tx_rsp_valid and the o_Enable_Checker pulse at N+2. If ready is already high, the handshake occurs at N+2 and o_done rises at N+3.
- DONE and ERROR hold their state; o_done or o_error stays 1 until i_start or reset.
- o_Final_MaxDataRate:
  - holds its last negotiated value through DONE, ERROR and IDLE
  - is unaffected by an ERROR from CHECK
  - is overwritten only in CHECK on success

Optional Feature:
- Macro PARAM_CHK_VSWING_EN.
- When defined, CHECK also errors with code 11 if i_rx_vswing > i_local_vswing or i_rx_vswing == 0. The rate check has priority: an invalid rate plus a bad vswing reports code 01.
- When undefined, vswing inputs are ignored, no code 11 is produced, and the rest of the behaviour is unchanged.

Test Plan:
- Nominal:
  - stimulus: local rate 3, clk 1, phase 0; rx rate 5, clk 1, phase 1; ready high.
  - response: at N+2 rsp valid with rate 3, clk 1, phase 0, one-cycle o_Enable_Checker, o_Final_MaxDataRate=3; o_done=1 at N+3.
- Invalid rate:
  - stimulus: rx rate 0.
  - response: ERROR, o_error_code=01, no rsp valid, no enable pulse, o_Final_MaxDataRate unchanged.
- Request timeout:
  - stimulus: TIMEOUT_CYCLES=16, no rx_valid after start.
  - response: o_error=1 with code 10 exactly 16 cycles after entering WAIT_REQ.
- Backpressure:
  - stimulus: ready low for 5 cycles, then high.
  - response: valid and fields stable for 6 cycles, enable pulsed once, o_done the cycle after the handshake.
- Restart:
  - stimulus: i_start asserted in SEND_RSP.
  - response: valid drops next cycle, state WAIT_REQ, o_done/o_error 0, new rx_valid renegotiates.
- With PARAM_CHK_VSWING_EN:
  - stimulus: local vswing 21, rx vswing 22.
  - response: ERROR with code 11.
  - Also check rx vswing 21: passes.
